kmp_fail_func_gen: RTL and testbench

KMP_FAIL_FUNC_GEN -- requirements
Module: kmp_fail_func_gen

---
 rtl/kmp_fail_func_gen.sv | 124 ++++++++++++
 tb/tb_kmp_fail_func_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/kmp_fail_func_gen.sv
// KMP failure-function generator: captures a pattern and computes the prefix
// table one symbol compare per cycle, then holds the result until acknowledged.
module kmp_fail_func_gen #(
  parameter int MAX_PAT = 32,
  parameter int IDX_W   = 5,
  parameter int BYTE_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic [MAX_PAT*BYTE_W-1:0] pattern,
  input  logic [IDX_W-1:0]          last_pat_idx,
  input  logic                      i_nocase,
  input  logic                      i_ack,
  output logic [MAX_PAT*IDX_W-1:0]  o_fail_func,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic [IDX_W:0]            o_steps
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(MAX_PAT - 1);

  state_t state_q, state_d;
  logic [MAX_PAT-1:0][BYTE_W-1:0] pat_q, pat_d;
  logic [MAX_PAT-1:0][IDX_W-1:0]  fail_q, fail_d;
  logic [IDX_W-1:0] last_q, last_d, i_q, i_d, k_q, k_d;
  logic [IDX_W:0]   steps_q, steps_d;
  logic             nocase_q, nocase_d;
  logic [IDX_W-1:0] last_clamp;
  logic             match, writes_last;

  // Upper-case ASCII letters when case-insensitive matching was captured.
  function automatic logic [BYTE_W-1:0] fold(input logic [BYTE_W-1:0] c, input logic nc);
    fold = c;
    if (nc && c >= BYTE_W'(8'h61) && c <= BYTE_W'(8'h7a)) fold = c - BYTE_W'(8'h20);
  endfunction

  assign last_clamp  = (last_pat_idx > LAST_MAX) ? LAST_MAX : last_pat_idx;
  assign match       = fold(pat_q[k_q], nocase_q) == fold(pat_q[i_q], nocase_q);
  assign writes_last = (match || k_q == '0) && (i_q == last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = (last_clamp == '0) ? DONE : CALC;
      CALC:    if (writes_last) state_d = DONE;
      DONE:    if (i_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      CALC:    o_busy  = 1'b1;
      DONE:    o_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pat_d    = pat_q;
    fail_d   = fail_q;
    last_d   = last_q;
    nocase_d = nocase_q;
    i_d      = i_q;
    k_d      = k_q;
    steps_d  = steps_q;
    if (state_q == IDLE && i_start) begin
      pat_d    = pattern;
      nocase_d = i_nocase;
      last_d   = last_clamp;
      fail_d   = '0;
      steps_d  = '0;
      i_d      = IDX_W'(1);
      k_d      = '0;
    end else if (state_q == CALC) begin
      steps_d = steps_q + 1'b1;
      if (match) begin
        fail_d[i_q] = k_q + 1'b1;
        k_d         = k_q + 1'b1;
        i_d         = i_q + 1'b1;
      end else if (k_q == '0) begin
        fail_d[i_q] = '0;
        i_d         = i_q + 1'b1;
      end else begin
        // Backtrack: retry the same i against a shorter border.
        k_d = fail_q[k_q - 1'b1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q    <= '0;
      fail_q   <= '0;
      last_q   <= '0;
      nocase_q <= 1'b0;
      i_q      <= '0;
      k_q      <= '0;
      steps_q  <= '0;
    end else begin
      pat_q    <= pat_d;
      fail_q   <= fail_d;
      last_q   <= last_d;
      nocase_q <= nocase_d;
      i_q      <= i_d;
      k_q      <= k_d;
      steps_q  <= steps_d;
    end
  end

  assign o_fail_func = fail_q;
  assign o_steps     = steps_q;

endmodule

// File: tb/tb_kmp_fail_func_gen.sv
// Bench for kmp_fail_func_gen: fixed scenarios plus random patterns against a
// brute-force border model.
module tb_kmp_fail_func_gen;
  localparam int MAX_PAT = 32;
  localparam int IDX_W   = 5;
  localparam int BYTE_W  = 8;

  logic clk = 1'b0;
  logic reset, i_start, i_nocase, i_ack;
  logic [MAX_PAT*BYTE_W-1:0] pattern;
  logic [IDX_W-1:0]          last_pat_idx;
  logic [MAX_PAT*IDX_W-1:0]  o_fail_func;
  logic                      o_valid, o_busy;
  logic [IDX_W:0]            o_steps;

  int errors = 0;
  int checks = 0;
  byte unsigned tp[MAX_PAT];
  int ref_f[MAX_PAT];
  int ref_steps;

  kmp_fail_func_gen #(.MAX_PAT(MAX_PAT), .IDX_W(IDX_W), .BYTE_W(BYTE_W)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .pattern(pattern),
    .last_pat_idx(last_pat_idx), .i_nocase(i_nocase), .i_ack(i_ack),
    .o_fail_func(o_fail_func), .o_valid(o_valid), .o_busy(o_busy), .o_steps(o_steps)
  );

  always #5 clk = ~clk;

  function automatic bit is_alpha(input byte unsigned c);
    return (c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a);
  endfunction

  function automatic bit sym_eq(input byte unsigned a, input byte unsigned b, input bit nc);
    if (nc && is_alpha(a) && is_alpha(b)) return (a | 8'h20) == (b | 8'h20);
    return a == b;
  endfunction

  // Longest proper border of each prefix by exhaustive search; step count from
  // the one-compare-per-step rule of the prefix-table walk.
  function automatic void calc_ref(input int last, input bit nc);
    int i, k;
    for (int q = 0; q < MAX_PAT; q++) begin
      ref_f[q] = 0;
      if (q <= last) begin
        for (int l = q; l >= 1; l--) begin
          bit ok = 1'b1;
          for (int j = 0; j < l; j++) if (!sym_eq(tp[j], tp[q-l+1+j], nc)) ok = 1'b0;
          if (ok) begin ref_f[q] = l; break; end
        end
      end
    end
    ref_steps = 0; i = 1; k = 0;
    while (i <= last) begin
      ref_steps++;
      if (sym_eq(tp[k], tp[i], nc)) begin k++; i++; end
      else if (k == 0) i++;
      else k = ref_f[k-1];
    end
  endfunction

  task automatic load_str(input string s);
    for (int q = 0; q < MAX_PAT; q++) tp[q] = (q < s.len()) ? s[q] : 8'($urandom);
  endtask

  task automatic drive_pat();
    for (int q = 0; q < MAX_PAT; q++) pattern[q*BYTE_W +: BYTE_W] = tp[q];
  endtask

  // Pulses start and waits for o_valid; lat = edges after capture until valid.
  task automatic run(input int last, input bit nc, output int lat, output int busy_cnt, output bit tmo);
    @(negedge clk);
    drive_pat(); last_pat_idx = IDX_W'(last); i_nocase = nc; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; busy_cnt = 0; tmo = 1'b1; lat = 0;
    for (int c = 0; c < 200; c++) begin
      if (o_valid) begin tmo = 1'b0; lat = c; break; end
      if (o_busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic ack();
    @(negedge clk); i_ack = 1'b1;
    @(negedge clk); i_ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_steps !== '0 || o_fail_func !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b steps=%0d fail=%h required all 0", o_valid, o_busy, o_steps, o_fail_func);
    end
  endtask

  // exp holds expected entries as digits; entries above last must be 0.
  task automatic test_known(input string name, input string s, input int last, input bit nc,
                            input string exp, input int exp_steps);
    int lat, bc; bit tmo;
    load_str(s);
    run(last, nc, lat, bc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL %s_timeout: o_valid never rose", name); return; end
    for (int q = 0; q < MAX_PAT; q++) begin
      int e = (q <= last) ? int'(exp[q]) - 48 : 0;
      checks++;
      if (o_fail_func[q*IDX_W +: IDX_W] !== IDX_W'(e)) begin
        errors++;
        $display("FAIL %s_entry%0d: got %0d required %0d", name, q, o_fail_func[q*IDX_W +: IDX_W], e);
      end
    end
    checks++;
    if (o_steps !== (IDX_W+1)'(exp_steps) || lat != exp_steps || bc != exp_steps) begin
      errors++;
      $display("FAIL %s_steps: steps=%0d latency=%0d busy=%0d required %0d", name, o_steps, lat, bc, exp_steps);
    end
    ack();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: valid=%b busy=%b required 0 0", name, o_valid, o_busy);
    end
  endtask

  task automatic test_random();
    int lat, bc, last; bit tmo, nc, bad;
    byte unsigned alpha[6] = '{8'h61, 8'h41, 8'h62, 8'h42, 8'h40, 8'h60};
    for (int t = 0; t < 40; t++) begin
      last = (t < 4) ? MAX_PAT - 1 : $urandom_range(0, MAX_PAT - 1);
      nc = 1'($urandom);
      for (int q = 0; q < MAX_PAT; q++) tp[q] = alpha[$urandom_range(0, (t % 2) ? 3 : 5)];
      calc_ref(last, nc);
      run(last, nc, lat, bc, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL rand%0d_timeout: o_valid never rose", t); return; end
      bad = 1'b0;
      for (int q = 0; q < MAX_PAT; q++) if (o_fail_func[q*IDX_W +: IDX_W] !== IDX_W'(ref_f[q])) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rand%0d_table: last=%0d nc=%0b got %h", t, last, nc, o_fail_func);
      end
      checks++;
      if (o_steps !== (IDX_W+1)'(ref_steps) || lat != ref_steps || int'(o_steps) > 2*last) begin
        errors++;
        $display("FAIL rand%0d_steps: got %0d latency %0d required %0d", t, o_steps, lat, ref_steps);
      end
      ack();
    end
  endtask

  task automatic test_reset_mid();
    load_str("AAAA");
    @(negedge clk);
    drive_pat(); last_pat_idx = 3; i_nocase = 1'b0; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL midreset_pre: busy=%b required 1", o_busy); end
    reset = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_steps !== '0 || o_fail_func !== '0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%b busy=%b steps=%0d fail=%h required all 0", o_valid, o_busy, o_steps, o_fail_func);
    end
    @(negedge clk); reset = 1'b0;
    test_known("restart", "ABAB", 3, 1'b0, "0012", 3);
  endtask

  task automatic test_hold_ack();
    int lat, bc; bit tmo;
    logic [MAX_PAT*IDX_W-1:0] ff;
    logic [IDX_W:0] st;
    load_str("ABAB");
    run(3, 1'b0, lat, bc, tmo);
    ff = o_fail_func; st = o_steps;
    checks++;
    if (tmo || ff[4*IDX_W-1:0] !== {5'd2, 5'd1, 5'd0, 5'd0} || st !== 6'd3) begin
      errors++;
      $display("FAIL hold_result: tmo=%b fail=%h steps=%0d required 0,0,1,2 and 3", tmo, ff, st);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      pattern = {8{$urandom}}; i_start = 1'($urandom); i_nocase = 1'($urandom);
      checks++;
      if (o_valid !== 1'b1 || o_fail_func !== ff || o_steps !== st) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b steps=%0d fail=%h required stable", c, o_valid, o_steps, o_fail_func);
      end
    end
    @(negedge clk); i_ack = 1'b1; i_start = 1'b1;
    @(negedge clk); i_ack = 1'b0; i_start = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_start_idle: valid=%b busy=%b required 0 0", o_valid, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_start_nocapture: valid=%b busy=%b required 0 0", o_valid, o_busy);
    end
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_nocase = 1'b0; i_ack = 1'b0;
    pattern = '0; last_pat_idx = '0;
    #1;
    test_reset();
    @(negedge clk); @(negedge clk); reset = 1'b0;
    test_known("ababc",   "ABABC",  4, 1'b0, "00120",  5);
    test_known("aabaaa",  "AABAAA", 5, 1'b0, "010122", 7);
    test_known("nocase1", "aAbA",   3, 1'b1, "0101",   4);
    test_known("nocase0", "aAbA",   3, 1'b0, "0000",   3);
    test_known("single",  "Z",      0, 1'b0, "0",      0);
    test_reset_mid();
    test_hold_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
